// File: rtl/lab1_sweep_pkg.sv
// ============================================================================
// Module  : lab1_sweep_pkg
// Brief   : Shared state encodings and sizing helpers for the lab1 key sweeper.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package lab1_sweep_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_SAMPLE = 2'd2;
  localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

  function automatic int vec_count(input int key_w);
    return 1 << key_w;
  endfunction

  // A one-cycle settle still needs a 1-bit counter to hold its reload of zero.
  function automatic int settle_cnt_w(input int settle_cyc);
    return (settle_cyc > 1) ? $clog2(settle_cyc) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lab1_sweep_timer.sv
// ============================================================================
// Module  : lab1_sweep_timer
// Brief   : Settle down-counter; expire is high once SETTLE_CYC-1 enabled
//           cycles have elapsed since the last load.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lab1_sweep_timer
  import lab1_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = settle_cnt_w(SETTLE_CYC);
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_reload;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expire = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/lab1_sweep_ctrl.sv
// ============================================================================
// Module  : lab1_sweep_ctrl
// Brief   : Drives the lab1 key bus through every value, samples the LED after
//           a settle window and builds the truth table. Optional golden-table
//           compare is enabled by defining LAB1_SWEEP_CMP_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module lab1_sweep_ctrl
  import lab1_sweep_pkg::*;
#(
  parameter int KEY_W      = 4,
  parameter int SETTLE_CYC = 2,
  parameter logic [vec_count(KEY_W)-1:0] EXPECTED = 16'h8000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [KEY_W-1:0]            key_o,
  input  logic                        led_i,
  output logic                        busy,
  output logic                        done,
  output logic [vec_count(KEY_W)-1:0] table_o
`ifdef LAB1_SWEEP_CMP_EN
  ,
  output logic [KEY_W:0]              mismatch_cnt,
  output logic [KEY_W-1:0]            fail_idx
`endif
);

  localparam int N = vec_count(KEY_W);
  localparam logic [KEY_W-1:0] c_key_last = KEY_W'(N - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [KEY_W-1:0]   r_key;
  logic [N-1:0]       r_table;
  logic               w_accept;
  logic               w_sample;
  logic               w_last;
  logic               w_expire;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_sample = (r_state == ST_SAMPLE);
  assign w_last   = (r_key == c_key_last);

  lab1_sweep_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_accept || (w_sample && !w_last)),
    .en     (r_state == ST_SETTLE),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start)    w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_expire) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_SETTLE, ST_SAMPLE: busy = 1'b1;
      ST_DONE:              done = 1'b1;
      default:              ;
    endcase
  end

  // The key only moves on a sample edge, so lab1 sees a steady bus while settling.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_key   <= '0;
      r_table <= '0;
    end else if (w_sample) begin
      r_table[r_key] <= led_i;
      r_key          <= w_last ? '0 : r_key + 1'b1;
    end
  end

  assign key_o   = r_key;
  assign table_o = r_table;

`ifdef LAB1_SWEEP_CMP_EN
  localparam logic [KEY_W:0] c_mis_max = (KEY_W + 1)'(N);

  logic [KEY_W:0]   r_mis_cnt;
  logic [KEY_W-1:0] r_fail_idx;
  logic             w_mis;

  assign w_mis = (led_i != EXPECTED[r_key]);

  // A zero count means no mismatch yet this sweep; it never returns to zero.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_mis_cnt  <= '0;
      r_fail_idx <= '0;
    end else if (w_sample && w_mis) begin
      if (r_mis_cnt != c_mis_max) begin
        r_mis_cnt <= r_mis_cnt + 1'b1;
      end
      if (r_mis_cnt == '0) begin
        r_fail_idx <= r_key;
      end
    end
  end

  assign mismatch_cnt = r_mis_cnt;
  assign fail_idx     = r_fail_idx;
`else
  logic w_unused_expected;
  assign w_unused_expected = ^EXPECTED;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lab1_sweep_ctrl.sv
// ============================================================================
// Module  : tb_lab1_sweep_ctrl
// Brief   : Bench for lab1_sweep_ctrl (default and KEY_W=2/SETTLE_CYC=1).
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lab1_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start1;
  logic        start2;
  logic [3:0]  key1;
  logic [1:0]  key2;
  logic        led1;
  logic        led2;
  logic        busy1;
  logic        done1;
  logic        busy2;
  logic        done2;
  logic [15:0] table1;
  logic [3:0]  table2;
`ifdef LAB1_SWEEP_CMP_EN
  logic [4:0]  mis1;
  logic [3:0]  fidx1;
  logic [2:0]  mis2;
  logic [1:0]  fidx2;
`endif

  int          mode;
  logic [15:0] rand_tt;
  int          sel;
  int          n_pass;
  int          n_total;

  always_comb begin
    led1 = 1'b0;
    case (mode)
      0:       led1 = &key1;
      1:       led1 = ^key1;
      default: led1 = rand_tt[key1];
    endcase
  end
  assign led2 = key2[0];

  lab1_sweep_ctrl u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start1),
    .key_o   (key1),
    .led_i   (led1),
    .busy    (busy1),
    .done    (done1),
    .table_o (table1)
`ifdef LAB1_SWEEP_CMP_EN
    ,
    .mismatch_cnt (mis1),
    .fail_idx     (fidx1)
`endif
  );

  lab1_sweep_ctrl #(
    .KEY_W      (2),
    .SETTLE_CYC (1),
    .EXPECTED   (4'b1010)
  ) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start2),
    .key_o   (key2),
    .led_i   (led2),
    .busy    (busy2),
    .done    (done2),
    .table_o (table2)
`ifdef LAB1_SWEEP_CMP_EN
    ,
    .mismatch_cnt (mis2),
    .fail_idx     (fidx2)
`endif
  );

  logic [3:0]  key_s;
  logic        busy_s;
  logic        done_s;
  logic [15:0] table_s;
  assign key_s   = (sel != 0) ? {2'b00, key2} : key1;
  assign busy_s  = (sel != 0) ? busy2 : busy1;
  assign done_s  = (sel != 0) ? done2 : done1;
  assign table_s = (sel != 0) ? {12'h000, table2} : table1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start2 = v;
    else start1 = v;
  endtask

  // Expected truth table straight from the LED rule for each key value.
  function automatic logic [15:0] model_table(input int m, input int n, input logic [15:0] tt);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < n; k++) begin
      case (m)
        0:       r[k] = (k == n - 1);
        1:       r[k] = ($countones(k) % 2) == 1;
        2:       r[k] = tt[k];
        default: r[k] = (k % 2) == 1;
      endcase
    end
    return r;
  endfunction

  function automatic int lowest_set(input logic [15:0] v);
    for (int k = 0; k < 16; k++) if (v[k]) return k;
    return 0;
  endfunction

  // One sweep on the selected DUT; optional stray start pulses at cycles 5 and 20.
  task automatic do_sweep(input int n, input int s, input logic [15:0] exp_tab,
                          input string tag, input bit pulses);
    int key_err;
    int ndone;
    int lat;
    key_err = 0;
    ndone   = 0;
    lat     = -1;
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    for (int t = 0; t < n * (s + 1) + 12; t++) begin
      set_start(pulses && (t == 5 || t == 20));
      if (done_s) begin
        ndone++;
        if (lat < 0) lat = t;
        if (busy_s !== 1'b0 || key_s !== 4'd0) key_err++;
      end
      if (t < n * (s + 1)) begin
        if (key_s !== 4'(t / (s + 1))) key_err++;
        if (busy_s !== 1'b1) key_err++;
      end
      @(negedge clk);
    end
    set_start(1'b0);
    check({tag, "_latency"}, 32'(lat), 32'(n * (s + 1)));
    check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    check({tag, "_key_seq"}, 32'(key_err), 32'd0);
    check({tag, "_table"}, {16'h0, table_s}, {16'h0, exp_tab});
  endtask

  typedef struct {
    int          mode;
    logic [15:0] tt;
    logic [15:0] exp_tab;
  } vec_t;

  vec_t vecs[6];
  int   done_t[$];
  int   ndone_rst;

  initial begin
    n_pass  = 0;
    n_total = 0;
    sel     = 0;
    mode    = 0;
    rand_tt = '0;

    for (int i = 0; i < 6; i++) begin
      vecs[i].mode    = (i < 2) ? i : 2;
      vecs[i].tt      = 16'($urandom);
      vecs[i].exp_tab = model_table(vecs[i].mode, 16, vecs[i].tt);
    end

    // Reset held with start high: nothing may begin.
    rst    = 1'b1;
    start1 = 1'b1;
    start2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset_out%0d", c), {10'h0, key1, busy1, done1, table1}, 32'h0);
    end
    check("reset_out_dut2", {24'h0, key2, busy2, done2, table2}, 32'h0);
    rst    = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {30'h0, busy1, done1}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      mode    = vecs[i].mode;
      rand_tt = vecs[i].tt;
      do_sweep(16, 2, vecs[i].exp_tab, $sformatf("vec%0d", i), 1'b0);
      check($sformatf("vec%0d_hold", i), {16'h0, table1}, {16'h0, vecs[i].exp_tab});
`ifdef LAB1_SWEEP_CMP_EN
      check($sformatf("vec%0d_mis", i), 32'(mis1),
            32'($countones(vecs[i].exp_tab ^ 16'h8000)));
      check($sformatf("vec%0d_fidx", i), 32'(fidx1),
            32'(lowest_set(vecs[i].exp_tab ^ 16'h8000)));
`endif
    end

    // Stray starts mid-sweep are ignored.
    mode = 0;
    do_sweep(16, 2, model_table(0, 16, 16'h0), "pulse", 1'b1);

    // Start held high: back-to-back sweeps every 50 cycles.
    mode = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    for (int t = 0; t < 160; t++) begin
      if (done1) done_t.push_back(t);
      @(negedge clk);
    end
    start1 = 1'b0;
    check("held_done_count", 32'(done_t.size()), 32'd3);
    if (done_t.size() == 3) begin
      check("held_first", 32'(done_t[0]), 32'd48);
      check("held_gap1", 32'(done_t[1] - done_t[0]), 32'd50);
      check("held_gap2", 32'(done_t[2] - done_t[1]), 32'd50);
    end
    for (int t = 0; t < 100 && (busy1 || done1); t++) @(negedge clk);
    check("held_idle", {30'h0, busy1, done1}, 32'h0);

    // Reset at cycle 25 of a sweep.
    mode = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int t = 0; t < 24; t++) @(negedge clk);
    check("pre_rst_partial", 32'(table1 != 16'h0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", {10'h0, key1, busy1, done1, table1}, 32'h0);
    ndone_rst = 0;
    for (int t = 0; t < 60; t++) begin
      if (done1 || busy1) ndone_rst++;
      @(negedge clk);
    end
    check("mid_rst_quiet", 32'(ndone_rst), 32'd0);
    do_sweep(16, 2, model_table(1, 16, 16'h0), "after_rst", 1'b0);
`ifdef LAB1_SWEEP_CMP_EN
    check("after_rst_mis", 32'(mis1), 32'd9);
    check("after_rst_fidx", 32'(fidx1), 32'd1);
`endif

    // Small configuration: KEY_W=2, SETTLE_CYC=1, LED = key[0].
    sel = 1;
    do_sweep(4, 1, model_table(3, 4, 16'h0), "corner", 1'b0);
`ifdef LAB1_SWEEP_CMP_EN
    check("corner_mis", 32'(mis2), 32'd0);
`endif
    sel = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
